// File: rtl/inst_rom.sv
// Instruction ROM for the CPU fetch port with a byte-serial program download loader.
// Reads are combinational and blocked while a download is in progress.
module inst_rom #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [31:0]   addr,
  output logic [31:0]   inst,
  input  logic          load_start_i,
  input  logic          load_end_i,
  input  logic          load_valid_i,
  input  logic [7:0]    load_byte_i,
  output logic          load_ready_o,
  output logic          busy_o,
  output logic [AW:0]   words_o,
  output logic          ovf_o
);

  localparam int unsigned WW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [23:0]     sh_q, sh_d;
  logic [WW-1:0]   words_q, words_d;
  logic            ovf_q, ovf_d;
  logic            accept;
  logic            last_byte;
  logic            full;
  logic            we;
  logic [31:0]     wdata;
  logic [AW-1:0]   rd_idx;
  logic            unused_addr;
  logic [31:0]     mem_q [DEPTH];

  assign accept    = (state_q == ST_LOAD) && load_valid_i;
  assign last_byte = accept && (cnt_q == 2'd3);
  assign full      = (words_q == WW'(DEPTH));
  assign wdata     = {sh_q, load_byte_i};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a completed word past capacity also ends the download
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_start_i) state_d = ST_LOAD;
      ST_LOAD: if (load_end_i || (last_byte && full)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader datapath and write strobe
  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          cnt_d   = 2'd0;
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              we      = 1'b1;
              words_d = words_q + WW'(1);
            end
          end else begin
            sh_d  = {sh_q[15:0], load_byte_i};
            cnt_d = cnt_q + 2'd1;
          end
        end
        // A partial word in flight when the download ends is dropped
        if (load_end_i) cnt_d = 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      sh_q    <= 24'd0;
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  // Memory is not reset so a program survives a CPU reset
  always_ff @(posedge clk) begin
    if (we) mem_q[words_q[AW-1:0]] <= wdata;
  end

  assign rd_idx       = addr[AW+1:2];
  assign unused_addr  = ^{addr[31:AW+2], addr[1:0]};
  assign busy_o       = (state_q == ST_LOAD);
  assign load_ready_o = (state_q == ST_LOAD);
  assign words_o      = words_q;
  assign ovf_o        = ovf_q;
  assign inst         = (ce && !busy_o) ? mem_q[rd_idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom.sv
// Randomized self-checking bench for inst_rom; a default-size instance plus a DEPTH=4
// instance for the capacity boundary, both checked against an array model of the ROM.
module tb_inst_rom;

  logic        clk;
  logic        rst;
  logic        ce, s_ce;
  logic [31:0] addr, s_addr;
  logic [31:0] inst, s_inst;
  logic        ld_start, ld_end, ld_valid;
  logic [7:0]  ld_byte;
  logic        s_start, s_end, s_valid;
  logic [7:0]  s_byte;
  logic        ready, busy, ovf;
  logic        s_ready, s_busy, s_ovf;
  logic [10:0] words;
  logic [2:0]  s_words;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [1024];

  inst_rom u_dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .load_start_i(ld_start), .load_end_i(ld_end), .load_valid_i(ld_valid),
    .load_byte_i(ld_byte), .load_ready_o(ready), .busy_o(busy),
    .words_o(words), .ovf_o(ovf)
  );

  inst_rom #(.DEPTH(4), .AW(2)) u_small (
    .clk(clk), .rst(rst), .ce(s_ce), .addr(s_addr), .inst(s_inst),
    .load_start_i(s_start), .load_end_i(s_end), .load_valid_i(s_valid),
    .load_byte_i(s_byte), .load_ready_o(s_ready), .busy_o(s_busy),
    .words_o(s_words), .ovf_o(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1; @(negedge clk); ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1; @(negedge clk); ld_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_end);
    ld_valid = 1'b1; ld_byte = b; ld_end = with_end;
    @(negedge clk);
    ld_valid = 1'b0; ld_end = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (24 - 8 * k)), 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    ce = 1'b1; addr = a; #1;
  endtask

  task automatic s_send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_byte = 8'(w >> (24 - 8 * k));
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || ready !== 1'b0) $display("FAIL reset_busy busy=%0b ready=%0b exp 0/0", busy, ready); else n_pass++;
    n_checks++; if (words !== 11'd0 || ovf !== 1'b0) $display("FAIL reset_words words=%0d ovf=%0b exp 0/0", words, ovf); else n_pass++;
    rst = 1'b0;
    tick();
    ce = 1'b0; addr = 32'h0; #1;
    n_checks++; if (inst !== 32'h0 || busy !== 1'b0) $display("FAIL reset_inst inst=%h busy=%0b exp 0/0", inst, busy); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] prog [8];
    prog = '{8'h24, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
    tick();
    pulse_start();
    n_checks++; if (busy !== 1'b1 || ready !== 1'b1) $display("FAIL basic_busy busy=%0b ready=%0b exp 1/1", busy, ready); else n_pass++;
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0);
    pulse_end();
    mdl[0] = 32'h24020001; mdl[1] = 32'h34030002;
    n_checks++; if (words !== 11'd2 || busy !== 1'b0) $display("FAIL basic_words words=%0d busy=%0b exp 2/0", words, busy); else n_pass++;
    rd(32'd0);
    n_checks++; if (inst !== 32'h24020001) $display("FAIL basic_rd0 got %h exp 24020001", inst); else n_pass++;
    rd(32'd4);
    n_checks++; if (inst !== 32'h34030002) $display("FAIL basic_rd4 got %h exp 34030002", inst); else n_pass++;
    rd(32'd6);
    n_checks++; if (inst !== 32'h34030002) $display("FAIL basic_rd6 got %h exp 34030002", inst); else n_pass++;
    rd({20'hABCDE, 10'd1, 2'b11});
    n_checks++; if (inst !== 32'h34030002) $display("FAIL basic_alias got %h exp 34030002", inst); else n_pass++;
  endtask

  task automatic test_blocking();
    logic [31:0] w0, w1, a;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; addr = a; #1;
      n_checks++; if (inst !== 32'h0) $display("FAIL ce_off addr=%h got %h exp 0", a, inst); else n_pass++;
    end
    tick();
    w0 = $urandom; w1 = $urandom;
    pulse_start();
    rd(32'd0);
    n_checks++; if (inst !== 32'h0 || ready !== 1'b1) $display("FAIL load_block inst=%h ready=%0b exp 0/1", inst, ready); else n_pass++;
    tick();
    send_word(w0);
    pulse_start();
    send_word(w1);
    pulse_end();
    mdl[0] = w0; mdl[1] = w1;
    n_checks++; if (words !== 11'd2) $display("FAIL no_restart words=%0d exp 2", words); else n_pass++;
    rd(32'd0);
    n_checks++; if (inst !== mdl[0]) $display("FAIL no_restart_rd0 got %h exp %h", inst, mdl[0]); else n_pass++;
    rd(32'd4);
    n_checks++; if (inst !== mdl[1]) $display("FAIL no_restart_rd4 got %h exp %h", inst, mdl[1]); else n_pass++;
  endtask

  task automatic test_partial();
    tick();
    pulse_start();
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    pulse_end();
    send_byte(8'hDD, 1'b0);
    tick();
    n_checks++; if (words !== 11'd0 || busy !== 1'b0) $display("FAIL partial_words words=%0d busy=%0b exp 0/0", words, busy); else n_pass++;
    rd(32'd0);
    n_checks++; if (inst !== mdl[0]) $display("FAIL partial_mem0 got %h exp %h", inst, mdl[0]); else n_pass++;
  endtask

  task automatic test_end_on_4th();
    logic [31:0] w;
    w = $urandom;
    tick();
    pulse_start();
    for (int k = 0; k < 3; k++) send_byte(8'(w >> (24 - 8 * k)), 1'b0);
    send_byte(w[7:0], 1'b1);
    mdl[0] = w;
    n_checks++; if (busy !== 1'b0 || words !== 11'd1) $display("FAIL end4_state busy=%0b words=%0d exp 0/1", busy, words); else n_pass++;
    rd(32'd0);
    n_checks++; if (inst !== mdl[0]) $display("FAIL end4_rd0 got %h exp %h", inst, mdl[0]); else n_pass++;
  endtask

  task automatic test_end_on_partial();
    logic [31:0] w;
    w = $urandom;
    tick();
    pulse_start();
    send_word(w);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    mdl[0] = w;
    n_checks++; if (busy !== 1'b0 || words !== 11'd1) $display("FAIL endp_state busy=%0b words=%0d exp 0/1", busy, words); else n_pass++;
    rd(32'd4);
    n_checks++; if (inst !== mdl[1]) $display("FAIL endp_rd4 got %h exp %h", inst, mdl[1]); else n_pass++;
  endtask

  task automatic test_random_programs();
    int unsigned n;
    logic [31:0] w, a;
    logic end_last;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 24);
      end_last = 1'($urandom_range(0, 1));
      tick();
      pulse_start();
      for (int unsigned i = 0; i < n; i++) begin
        w = $urandom;
        mdl[i] = w;
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 3) == 0) tick();
          send_byte(8'(w >> (24 - 8 * k)), end_last && (i == n - 1) && (k == 3));
        end
      end
      if (!end_last) pulse_end();
      n_checks++; if (words !== 11'(n) || busy !== 1'b0 || ovf !== 1'b0) $display("FAIL rand_words run=%0d words=%0d busy=%0b ovf=%0b exp %0d/0/0", r, words, busy, ovf, n); else n_pass++;
      for (int unsigned j = 0; j < n; j++) begin
        a = $urandom;
        a[11:2] = 10'(j);
        rd(a);
        n_checks++; if (inst !== mdl[j]) $display("FAIL rand_rd run=%0d addr=%h got %h exp %h", r, a, inst, mdl[j]); else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] sw [5];
    for (int i = 0; i < 5; i++) sw[i] = $urandom;
    tick();
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 4; i++) s_send_word(sw[i]);
    n_checks++; if (s_words !== 3'd4 || s_ovf !== 1'b0 || s_busy !== 1'b1) $display("FAIL ovf_full words=%0d ovf=%0b busy=%0b exp 4/0/1", s_words, s_ovf, s_busy); else n_pass++;
    s_send_word(sw[4]);
    n_checks++; if (s_words !== 3'd4 || s_ovf !== 1'b1) $display("FAIL ovf_set words=%0d ovf=%0b exp 4/1", s_words, s_ovf); else n_pass++;
    n_checks++; if (s_busy !== 1'b0 || s_ready !== 1'b0) $display("FAIL ovf_idle busy=%0b ready=%0b exp 0/0", s_busy, s_ready); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      s_ce = 1'b1; s_addr = 32'(4 * i); #1;
      n_checks++; if (s_inst !== sw[i % 4]) $display("FAIL ovf_rd addr=%0d got %h exp %h", 4 * i, s_inst, sw[i % 4]); else n_pass++;
    end
    tick();
    s_start = 1'b1; tick(); s_start = 1'b0;
    n_checks++; if (s_ovf !== 1'b0 || s_words !== 3'd0) $display("FAIL ovf_clear ovf=%0b words=%0d exp 0/0", s_ovf, s_words); else n_pass++;
    s_end = 1'b1; tick(); s_end = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] w;
    w = $urandom;
    tick();
    pulse_start();
    send_word(w);
    pulse_end();
    mdl[0] = w;
    pulse_start();
    send_byte(8'h5A, 1'b0); send_byte(8'hA5, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || ready !== 1'b0 || words !== 11'd0) $display("FAIL abort_state busy=%0b ready=%0b words=%0d exp 0/0/0", busy, ready, words); else n_pass++;
    rd(32'd0);
    n_checks++; if (inst !== mdl[0]) $display("FAIL abort_mem0 got %h exp %h", inst, mdl[0]); else n_pass++;
    tick();
    send_word($urandom);
    tick();
    n_checks++; if (busy !== 1'b0 || words !== 11'd0) $display("FAIL idle_bytes busy=%0b words=%0d exp 0/0", busy, words); else n_pass++;
    rd(32'd0);
    n_checks++; if (inst !== mdl[0]) $display("FAIL idle_bytes_mem0 got %h exp %h", inst, mdl[0]); else n_pass++;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; addr = 32'h0;
    ld_start = 1'b0; ld_end = 1'b0; ld_valid = 1'b0; ld_byte = 8'h0;
    s_ce = 1'b0; s_addr = 32'h0;
    s_start = 1'b0; s_end = 1'b0; s_valid = 1'b0; s_byte = 8'h0;
    test_reset();
    test_basic();
    test_blocking();
    test_partial();
    test_end_on_4th();
    test_end_on_partial();
    test_random_programs();
    test_overflow();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
